// File: rtl/stream_router.sv
// Routes one valid/ready input stream to N_OUT output streams by per-beat destination,
// with a small FIFO per output; out-of-range destinations are dropped and counted.
module stream_router #(
   parameter int N_OUT = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int DW    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_in_valid,
   output logic                     io_in_ready,
   input  logic [WIDTH-1:0]         io_in_bits,
   input  logic [DW-1:0]            io_in_dest,
   output logic                     io_out_0_valid,
   input  logic                     io_out_0_ready,
   output logic [WIDTH-1:0]         io_out_0_bits,
   output logic [$clog2(DEPTH):0]   io_out_0_count,
   output logic                     io_out_1_valid,
   input  logic                     io_out_1_ready,
   output logic [WIDTH-1:0]         io_out_1_bits,
   output logic [$clog2(DEPTH):0]   io_out_1_count,
   output logic                     io_out_2_valid,
   input  logic                     io_out_2_ready,
   output logic [WIDTH-1:0]         io_out_2_bits,
   output logic [$clog2(DEPTH):0]   io_out_2_count,
   output logic                     io_out_3_valid,
   input  logic                     io_out_3_ready,
   output logic [WIDTH-1:0]         io_out_3_bits,
   output logic [$clog2(DEPTH):0]   io_out_3_count,
   output logic                     io_out_4_valid,
   input  logic                     io_out_4_ready,
   output logic [WIDTH-1:0]         io_out_4_bits,
   output logic [$clog2(DEPTH):0]   io_out_4_count,
   output logic                     io_out_5_valid,
   input  logic                     io_out_5_ready,
   output logic [WIDTH-1:0]         io_out_5_bits,
   output logic [$clog2(DEPTH):0]   io_out_5_count,
   output logic                     io_out_6_valid,
   input  logic                     io_out_6_ready,
   output logic [WIDTH-1:0]         io_out_6_bits,
   output logic [$clog2(DEPTH):0]   io_out_6_count,
   output logic                     io_out_7_valid,
   input  logic                     io_out_7_ready,
   output logic [WIDTH-1:0]         io_out_7_bits,
   output logic [$clog2(DEPTH):0]   io_out_7_count,
   output logic [7:0]               io_dropped
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]       out_ready, out_valid, full, dest_hit;
   logic [WIDTH-1:0] out_bits  [8];
   logic [CW-1:0]    out_count [8];
   logic             dest_oob, in_fire;
   logic [7:0]       drop_q, drop_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (DEPTH == 1) ? '0 : p + 1'b1;
   endfunction

   assign out_ready = {io_out_7_ready, io_out_6_ready, io_out_5_ready, io_out_4_ready,
                       io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

   assign dest_oob    = (int'(io_in_dest) >= N_OUT);
   // Ready looks only at the selected FIFO's fullness, never at output readies.
   assign io_in_ready = reset && (dest_oob || ((full & dest_hit) == '0));
   assign in_fire     = io_in_valid && io_in_ready;

   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign dest_hit[i] = (int'(io_in_dest) == i);
      if (i < N_OUT) begin : g_fifo
         logic [WIDTH-1:0] mem_q [DEPTH];
         logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
         logic [CW-1:0]    cnt_q, cnt_d;
         logic             enq, deq;

         assign enq           = in_fire && dest_hit[i];
         assign deq           = out_valid[i] && out_ready[i];
         assign full[i]       = (cnt_q == CW'(DEPTH));
         assign out_valid[i]  = reset && (cnt_q != '0);
         assign out_bits[i]   = out_valid[i] ? mem_q[head_q] : '0;
         assign out_count[i]  = cnt_q;

         always_comb begin
            head_d = deq ? ptr_inc(head_q) : head_q;
            tail_d = enq ? ptr_inc(tail_q) : tail_q;
            cnt_d  = cnt_q;
            if (enq && !deq)      cnt_d = cnt_q + 1'b1;
            else if (!enq && deq) cnt_d = cnt_q - 1'b1;
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               head_q <= '0;
               tail_q <= '0;
               cnt_q  <= '0;
            end else begin
               head_q <= head_d;
               tail_q <= tail_d;
               cnt_q  <= cnt_d;
            end
         end

         // Payload storage carries no reset; emptiness is tracked by cnt_q alone.
         always_ff @(posedge clk) begin
            if (enq) mem_q[tail_q] <= io_in_bits;
         end
      end else begin : g_none
         logic unused_rdy;
         assign unused_rdy    = out_ready[i];
         assign full[i]       = 1'b0;
         assign out_valid[i]  = 1'b0;
         assign out_bits[i]   = '0;
         assign out_count[i]  = '0;
      end
   end

   assign drop_d = (in_fire && dest_oob && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

   always_ff @(posedge clk) begin
      if (!reset) drop_q <= '0;
      else        drop_q <= drop_d;
   end
   assign io_dropped = drop_q;

   assign io_out_0_valid = out_valid[0]; assign io_out_0_bits = out_bits[0]; assign io_out_0_count = out_count[0];
   assign io_out_1_valid = out_valid[1]; assign io_out_1_bits = out_bits[1]; assign io_out_1_count = out_count[1];
   assign io_out_2_valid = out_valid[2]; assign io_out_2_bits = out_bits[2]; assign io_out_2_count = out_count[2];
   assign io_out_3_valid = out_valid[3]; assign io_out_3_bits = out_bits[3]; assign io_out_3_count = out_count[3];
   assign io_out_4_valid = out_valid[4]; assign io_out_4_bits = out_bits[4]; assign io_out_4_count = out_count[4];
   assign io_out_5_valid = out_valid[5]; assign io_out_5_bits = out_bits[5]; assign io_out_5_count = out_count[5];
   assign io_out_6_valid = out_valid[6]; assign io_out_6_bits = out_bits[6]; assign io_out_6_count = out_count[6];
   assign io_out_7_valid = out_valid[7]; assign io_out_7_bits = out_bits[7]; assign io_out_7_count = out_count[7];
endmodule

// File: tb/tb_stream_router.sv
// Bench for stream_router: a 4-output and a 3-output instance, each checked every cycle
// against a queue-based model, plus directed sequences with literal expectations.
module tb_stream_router;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       vld  [2];
   logic [7:0] bits [2];
   logic [1:0] dest [2];
   logic       rdy  [2];
   logic       ov   [2][8];
   logic       ordy [2][8];
   logic [7:0] ob   [2][8];
   logic [1:0] oc   [2][8];
   logic [7:0] drop [2];

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;

   stream_router #(.N_OUT(4), .WIDTH(8), .DEPTH(DEPTH), .DW(2)) dut_a (
      .clk(clk), .reset(rst_n), .io_in_valid(vld[0]), .io_in_ready(rdy[0]),
      .io_in_bits(bits[0]), .io_in_dest(dest[0]), .io_dropped(drop[0]),
      .io_out_0_valid(ov[0][0]), .io_out_0_ready(ordy[0][0]), .io_out_0_bits(ob[0][0]), .io_out_0_count(oc[0][0]),
      .io_out_1_valid(ov[0][1]), .io_out_1_ready(ordy[0][1]), .io_out_1_bits(ob[0][1]), .io_out_1_count(oc[0][1]),
      .io_out_2_valid(ov[0][2]), .io_out_2_ready(ordy[0][2]), .io_out_2_bits(ob[0][2]), .io_out_2_count(oc[0][2]),
      .io_out_3_valid(ov[0][3]), .io_out_3_ready(ordy[0][3]), .io_out_3_bits(ob[0][3]), .io_out_3_count(oc[0][3]),
      .io_out_4_valid(ov[0][4]), .io_out_4_ready(ordy[0][4]), .io_out_4_bits(ob[0][4]), .io_out_4_count(oc[0][4]),
      .io_out_5_valid(ov[0][5]), .io_out_5_ready(ordy[0][5]), .io_out_5_bits(ob[0][5]), .io_out_5_count(oc[0][5]),
      .io_out_6_valid(ov[0][6]), .io_out_6_ready(ordy[0][6]), .io_out_6_bits(ob[0][6]), .io_out_6_count(oc[0][6]),
      .io_out_7_valid(ov[0][7]), .io_out_7_ready(ordy[0][7]), .io_out_7_bits(ob[0][7]), .io_out_7_count(oc[0][7]));

   stream_router #(.N_OUT(3), .WIDTH(8), .DEPTH(DEPTH), .DW(2)) dut_b (
      .clk(clk), .reset(rst_n), .io_in_valid(vld[1]), .io_in_ready(rdy[1]),
      .io_in_bits(bits[1]), .io_in_dest(dest[1]), .io_dropped(drop[1]),
      .io_out_0_valid(ov[1][0]), .io_out_0_ready(ordy[1][0]), .io_out_0_bits(ob[1][0]), .io_out_0_count(oc[1][0]),
      .io_out_1_valid(ov[1][1]), .io_out_1_ready(ordy[1][1]), .io_out_1_bits(ob[1][1]), .io_out_1_count(oc[1][1]),
      .io_out_2_valid(ov[1][2]), .io_out_2_ready(ordy[1][2]), .io_out_2_bits(ob[1][2]), .io_out_2_count(oc[1][2]),
      .io_out_3_valid(ov[1][3]), .io_out_3_ready(ordy[1][3]), .io_out_3_bits(ob[1][3]), .io_out_3_count(oc[1][3]),
      .io_out_4_valid(ov[1][4]), .io_out_4_ready(ordy[1][4]), .io_out_4_bits(ob[1][4]), .io_out_4_count(oc[1][4]),
      .io_out_5_valid(ov[1][5]), .io_out_5_ready(ordy[1][5]), .io_out_5_bits(ob[1][5]), .io_out_5_count(oc[1][5]),
      .io_out_6_valid(ov[1][6]), .io_out_6_ready(ordy[1][6]), .io_out_6_bits(ob[1][6]), .io_out_6_count(oc[1][6]),
      .io_out_7_valid(ov[1][7]), .io_out_7_ready(ordy[1][7]), .io_out_7_bits(ob[1][7]), .io_out_7_count(oc[1][7]));

   task automatic chk(input string nm, input int k, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d port=%0d got=%0h want=%0h t=%0t", nm, k, i, act, exp, $time);
      end
   endtask

   // Reference model: one queue per output, drop counter per instance.
   logic [7:0] mq [2][8][$];
   int         mdrop [2];
   int         nout  [2] = '{4, 3};

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int i = 0; i < 8; i++) mq[k][i].delete();
            mdrop[k] <= 0;
         end else begin
            if (vld[k] && int'(dest[k]) >= nout[k] && mdrop[k] < 255) mdrop[k] <= mdrop[k] + 1;
            for (int i = 0; i < nout[k]; i++) begin
               int sz;
               sz = mq[k][i].size();
               if (sz != 0 && ordy[k][i]) void'(mq[k][i].pop_front());
               if (vld[k] && int'(dest[k]) == i && sz < DEPTH) mq[k][i].push_back(bits[k]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            int qs;
            logic er;
            logic [7:0] eb;
            if (int'(dest[k]) >= nout[k]) er = rst_n;
            else er = rst_n && (mq[k][int'(dest[k])].size() < DEPTH);
            chk("in_ready", k, 8, 32'(rdy[k]), 32'(er));
            for (int i = 0; i < 8; i++) begin
               qs = (i < nout[k]) ? mq[k][i].size() : 0;
               eb = (rst_n && qs != 0) ? mq[k][i][0] : 8'h00;
               chk("out_valid", k, i, 32'(ov[k][i]), 32'(rst_n && qs != 0));
               chk("out_bits",  k, i, 32'(ob[k][i]), 32'(eb));
               chk("out_count", k, i, 32'(oc[k][i]), 32'(qs));
            end
            chk("dropped", k, 8, 32'(drop[k]), 32'(mdrop[k]));
         end
      end
   end

   // Protocol monitor: payload and destination must hold while a beat is stalled.
   logic       hold_v [2] = '{1'b0, 1'b0};
   logic [7:0] hold_b [2];
   logic [1:0] hold_d [2];
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (hold_v[k] && vld[k])
            assert (bits[k] == hold_b[k] && dest[k] == hold_d[k])
               else $error("stalled input changed on instance %0d", k);
         hold_v[k] <= rst_n && vld[k] && !rdy[k];
         hold_b[k] <= bits[k];
         hold_d[k] <= dest[k];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vld[k] = 1'b1; bits[k] = 8'h5A; dest[k] = 2'd0;
         for (int i = 0; i < 8; i++) ordy[k][i] = 1'b1;
      end
      dest[1] = 2'd3;
      step(); started = 1'b1; step(); step();
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", k, 8, 32'(rdy[k]), 0);
         chk("rst_drop", k, 8, 32'(drop[k]), 0);
         for (int i = 0; i < 8; i++) begin
            chk("rst_valid", k, i, 32'(ov[k][i]), 0);
            chk("rst_bits", k, i, 32'(ob[k][i]), 0);
            chk("rst_count", k, i, 32'(oc[k][i]), 0);
         end
      end

      // Routing and one-cycle latency.
      rst_n = 1'b1; vld[1] = 1'b0;
      bits[0] = 8'h11; dest[0] = 2'd0; #1;
      chk("route_rdy", 0, 0, 32'(rdy[0]), 1);
      step(); bits[0] = 8'h22; dest[0] = 2'd1; #1;
      chk("route_v0", 0, 0, 32'(ov[0][0]), 1);
      chk("route_b0", 0, 0, 32'(ob[0][0]), 32'h11);
      chk("route_c0", 0, 0, 32'(oc[0][0]), 1);
      step(); bits[0] = 8'h33; dest[0] = 2'd2; #1;
      chk("route_v0_gone", 0, 0, 32'(ov[0][0]), 0);
      chk("route_b1", 0, 1, 32'(ob[0][1]), 32'h22);
      step(); bits[0] = 8'h44; dest[0] = 2'd3; #1;
      chk("route_b2", 0, 2, 32'(ob[0][2]), 32'h33);
      step(); vld[0] = 1'b0; #1;
      chk("route_b3", 0, 3, 32'(ob[0][3]), 32'h44);
      step();
      for (int i = 0; i < 4; i++) chk("route_empty", 0, i, 32'(oc[0][i]), 0);

      // Full FIFO blocks the input; no pass-through on a full queue.
      ordy[0][2] = 1'b0; vld[0] = 1'b1; dest[0] = 2'd2; bits[0] = 8'hA0;
      step(); bits[0] = 8'hA1;
      step(); bits[0] = 8'hA2; #1;
      chk("full_cnt", 0, 2, 32'(oc[0][2]), 2);
      chk("full_rdy", 0, 2, 32'(rdy[0]), 0);
      chk("full_head", 0, 2, 32'(ob[0][2]), 32'hA0);
      step();
      chk("stall_rdy", 0, 2, 32'(rdy[0]), 0);
      ordy[0][2] = 1'b1; #1;
      chk("nopass_rdy", 0, 2, 32'(rdy[0]), 0);
      step();
      chk("drain1_head", 0, 2, 32'(ob[0][2]), 32'hA1);
      chk("drain1_cnt", 0, 2, 32'(oc[0][2]), 1);
      chk("drain1_rdy", 0, 2, 32'(rdy[0]), 1);
      step(); vld[0] = 1'b0; #1;
      chk("drain2_head", 0, 2, 32'(ob[0][2]), 32'hA2);
      chk("drain2_cnt", 0, 2, 32'(oc[0][2]), 1);
      step();
      chk("drain3_cnt", 0, 2, 32'(oc[0][2]), 0);

      // Independence: output 0 stuck full, output 1 keeps flowing.
      ordy[0][0] = 1'b0; vld[0] = 1'b1; dest[0] = 2'd0; bits[0] = 8'hB0;
      step(); bits[0] = 8'hB1;
      step(); bits[0] = 8'hB2; #1;
      chk("ind_block", 0, 0, 32'(rdy[0]), 0);
      step(); vld[0] = 1'b0;
      step(); vld[0] = 1'b1; dest[0] = 2'd1; bits[0] = 8'hC0; #1;
      chk("ind_rdy", 0, 1, 32'(rdy[0]), 1);
      step(); bits[0] = 8'hC1; #1;
      chk("ind_b1", 0, 1, 32'(ob[0][1]), 32'hC0);
      chk("ind_c0", 0, 0, 32'(oc[0][0]), 2);
      step(); bits[0] = 8'hC2; #1;
      chk("ind_b1b", 0, 1, 32'(ob[0][1]), 32'hC1);
      step(); vld[0] = 1'b0; #1;
      chk("ind_b1c", 0, 1, 32'(ob[0][1]), 32'hC2);
      chk("ind_c0b", 0, 0, 32'(oc[0][0]), 2);
      ordy[0][0] = 1'b1;
      step(); step(); step();
      chk("ind_drain0", 0, 0, 32'(oc[0][0]), 0);
      chk("ind_drain1", 0, 1, 32'(oc[0][1]), 0);

      // Sustained enqueue+dequeue on FIFO 3 at count 1, wrapping pointers.
      ordy[0][3] = 1'b0; vld[0] = 1'b1; dest[0] = 2'd3; bits[0] = 8'hD0;
      step(); ordy[0][3] = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         bits[0] = 8'hD0 + 8'(j); #1;
         chk("sim_cnt", 0, 3, 32'(oc[0][3]), 1);
         chk("sim_head", 0, 3, 32'(ob[0][3]), 32'(8'hD0 + 8'(j - 1)));
         step();
      end
      vld[0] = 1'b0; #1;
      chk("sim_last", 0, 3, 32'(ob[0][3]), 32'hDA);
      step();
      chk("sim_empty", 0, 3, 32'(oc[0][3]), 0);

      // Randomized traffic on the 4-output instance.
      for (int c = 0; c < 1500; c++) begin
         if (!(hold_v[0] && vld[0])) begin
            vld[0]  = ($urandom_range(0, 3) != 0);
            bits[0] = 8'($urandom);
            dest[0] = 2'($urandom_range(0, 3));
         end
         for (int i = 0; i < 4; i++) ordy[0][i] = ($urandom_range(0, 2) != 0);
         step();
      end
      vld[0] = 1'b0;
      for (int i = 0; i < 4; i++) ordy[0][i] = 1'b1;
      step(); step(); step();

      // Out-of-range destination on the 3-output instance: drops saturate at 255.
      vld[1] = 1'b1; dest[1] = 2'd3;
      for (int c = 1; c <= 300; c++) begin
         bits[1] = 8'($urandom); #1;
         chk("drop_rdy", 1, 3, 32'(rdy[1]), 1);
         step();
         chk("drop_cnt", 1, 3, 32'(drop[1]), 32'((c < 255) ? c : 255));
      end

      // Reset with both instances holding queued beats.
      dest[1] = 2'd0; bits[1] = 8'h77; ordy[1][0] = 1'b0;
      vld[0] = 1'b1; dest[0] = 2'd2; bits[0] = 8'h66; ordy[0][2] = 1'b0;
      step(); step();
      vld[0] = 1'b0; vld[1] = 1'b0; #1;
      chk("pre_rst_b", 1, 0, 32'(oc[1][0]), 2);
      chk("pre_rst_a", 0, 2, 32'(oc[0][2]), 2);
      rst_n = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         chk("flush_drop", k, 8, 32'(drop[k]), 0);
         for (int i = 0; i < 8; i++) begin
            chk("flush_cnt", k, i, 32'(oc[k][i]), 0);
            chk("flush_valid", k, i, 32'(ov[k][i]), 0);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin ordy[0][i] = 1'b1; ordy[1][i] = 1'b1; end
      step(); step();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++) chk("post_rst_valid", k, i, 32'(ov[k][i]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stream_router.md
Name: stream_router

Overview:
- One-to-many counterpart of the fixed-priority stream arbiter: one decoupled valid/ready input stream is routed to one of N_OUT decoupled output streams by a per-beat destination index.
- Each output has a small FIFO so that slow consumers do not stall traffic already queued for other outputs.
- The block sits on the fan-out side of the shared interconnect, downstream of the arbiters that merge requesters.

Parameters:
- N_OUT, 4, number of output ports (2..8).
- WIDTH, 8, payload width in bits.
- DEPTH, 2, entries per output FIFO (power of two, ≥1).
- DW, 2, width of io_in_dest; must satisfy 2^DW ≥ N_OUT.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0); sampled on the rising edge of clk.
- io_in_valid  input  1  input beat valid.
- io_in_ready  output  1  input beat accepted when valid && ready.
- io_in_bits  input  WIDTH  input payload.
- io_in_dest  input  DW  destination output index.
- io_out_<i>_valid  output  1  output i has a beat (i = 0..N_OUT-1).
- io_out_<i>_ready  input  1  consumer i accepts the beat.
- io_out_<i>_bits  output  WIDTH  head-of-FIFO payload for output i.
- io_out_<i>_count  output  log2(DEPTH)+1  occupancy of FIFO i.
- io_dropped  output  8  saturating count of beats discarded for an out-of-range destination.

Behaviour:
- Reset (reset==0 at a clock edge):
  - All FIFOs empty; pointers and io_out_<i>_count = 0; io_dropped = 0.
  - While reset is held: io_in_ready = 0, all io_out_<i>_valid = 0, all io_out_<i>_bits = 0.
  - Reset mid-operation flushes every queued beat; no beat is emitted after reset deasserts until it is re-enqueued.
- io_in_ready (combinational, no dependence on io_in_valid):
  - dest < N_OUT: ready = !full[dest].
  - dest ≥ N_OUT: ready = 1.
- Enqueue: on valid && ready with dest < N_OUT, bits are written at FIFO[dest] tail; tail pointer and count advance.
- Drop: on valid && ready with dest ≥ N_OUT, the beat is discarded and io_dropped increments, saturating at 255.
- Latency: an accepted beat appears on io_out_<dest>_valid/bits at the next clock edge. There is no combinational input-to-output bypass.
- Output i:
  - valid = count_i ≠ 0; bits = entry at the head pointer (0 when empty).
  - Dequeue on valid && ready; head advances.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH; full = (count == DEPTH).
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, both pointers advance.
  - On a full FIFO, io_in_ready = 0 that cycle even if the consumer dequeues. Full-queue pass-through is not allowed, which keeps ready free of output-ready paths.
- Head-of-line blocking: if the current beat's destination is full, the input stalls. Other outputs keep draining independently.
- Ordering: beats to the same output leave in arrival order. No ordering is guaranteed across different outputs.
- io_in_bits and io_in_dest must be held stable while valid && !ready. Behaviour is undefined otherwise, and an assertion in the bench checks it.

Test Plan:
- Reset: hold reset=0 for 3 cycles with io_in_valid=1 → io_in_ready=0, all out valid=0, all bits=0, all counts=0, io_dropped=0.
- Routing and latency: send 0x11→dest 0, 0x22→dest 1, 0x33→dest 2, 0x44→dest 3 on consecutive cycles with all outs ready → each appears on its port exactly 1 cycle after acceptance, with the correct bits; counts return to 0.
- Full and blocking: io_out_2_ready=0, send 0xA0, 0xA1, 0xA2 to dest 2 → first two accepted, count_2=2, io_in_ready=0 on the third. Then raise io_out_2_ready → 0xA0, 0xA1, 0xA2 emerge in order; the third is accepted on the cycle after the first dequeue.
- Independence: dest 0 blocked full, then switch the input to dest 1 → io_in_ready=1 and output 1 traffic flows while count_0 stays 2.
- Simultaneous enqueue/dequeue on FIFO 3 at count=1, sustained for 10 cycles → count_3 stays 1, every beat delivered exactly once in order; pointer wrap exercised.
- Drop and reset: with N_OUT=3 (DW=2) send 300 beats to dest 3 → io_in_ready=1 throughout, io_dropped saturates at 255. Then assert reset with FIFOs non-empty → all counts 0 and valids 0 on the next edge.
